typing_test_ctrl: RTL and testbench

//  Moore FSM that sequences the typing-test datapath.
//  - Drives every en_*/s_* select of the datapath and consumes its status flags.
//  - Arms and stops the stopwatch, walks the text ROM address, echoes correct keys to UART TX.
//  - Counts correct and wrong keystrokes.

---
 rtl/typing_test_ctrl.sv | 166 ++++++++++++++++
 tb/tb_typing_test_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/typing_test_ctrl.sv
// Moore controller for the typing-test datapath: sequences game start, key matching,
// UART echo of correct keys, end-of-text CR and keystroke statistics.
module typing_test_ctrl #(
    parameter int unsigned ROM_LAT    = 2,
    parameter int unsigned TX_TIMEOUT = 100000,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_pressed_eq_1,
    input  logic             start_of_game,
    input  logic             rom_eq_uart,
    input  logic             end_of_game,
    input  logic             stopwatch_start_eq_0_and_rom_eq_0,
    input  logic             tx_done,
    output logic             en_curr_addr,
    output logic [1:0]       s_curr_addr,
    output logic             en_stopwatch_rst,
    output logic             s_stopwatch_rst,
    output logic             en_stopwatch_start,
    output logic             s_stopwatch_start,
    output logic             en_out_byte,
    output logic [1:0]       s_out_byte,
    output logic             en_uart_tx_go,
    output logic             s_uart_tx_go,
    output logic             game_active,
    output logic [CNT_W-1:0] key_count,
    output logic [CNT_W-1:0] err_count
);

    // One counter serves both the TX timeout and the ROM latency wait.
    localparam int unsigned TmoMax = (TX_TIMEOUT > ROM_LAT) ? TX_TIMEOUT : ROM_LAT;
    localparam int unsigned TmoW   = $clog2(TmoMax + 1);

    typedef enum logic [3:0] {
        StIdle, StArm, StKey, StMatch, StTxGo, StTxClr, StTxWait, StRomWait,
        StEndCr, StEndGo, StEndClr, StEndWait, StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             tmo_tx_last, tmo_rom_last;

    assign tmo_tx_last  = (tmo_q == TmoW'(TX_TIMEOUT - 1));
    assign tmo_rom_last = (tmo_q == TmoW'(ROM_LAT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            key_cnt_q <= '0;
            err_cnt_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            key_cnt_q <= key_cnt_d;
            err_cnt_q <= err_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        key_cnt_d          = key_cnt_q;
        err_cnt_d          = err_cnt_q;
        tmo_d              = tmo_q;
        en_curr_addr       = 1'b0;
        s_curr_addr        = 2'd0;
        en_stopwatch_rst   = 1'b0;
        s_stopwatch_rst    = 1'b0;
        en_stopwatch_start = 1'b0;
        s_stopwatch_start  = 1'b0;
        en_out_byte        = 1'b0;
        s_out_byte         = 2'd0;
        en_uart_tx_go      = 1'b0;
        s_uart_tx_go       = 1'b0;

        unique case (state_q)
            StIdle: begin
                en_curr_addr       = 1'b1;
                en_stopwatch_rst   = 1'b1;
                s_stopwatch_rst    = 1'b1;
                en_stopwatch_start = 1'b1;
                en_uart_tx_go      = 1'b1;
                if (start_of_game) begin
                    state_d = stopwatch_start_eq_0_and_rom_eq_0 ? StEndCr : StArm;
                end
            end
            StArm: begin
                en_stopwatch_rst   = 1'b1;
                en_stopwatch_start = 1'b1;
                s_stopwatch_start  = 1'b1;
                key_cnt_d          = '0;
                err_cnt_d          = '0;
                state_d            = StKey;
            end
            StKey: begin
                en_curr_addr = 1'b1;
                s_curr_addr  = 2'd2;
                // End of game wins over a same-cycle key, which is dropped.
                if (end_of_game) begin
                    state_d = StEndCr;
                end else if (uart_pressed_eq_1) begin
                    if (rom_eq_uart) begin
                        state_d = StMatch;
                    end else if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
            end
            StMatch: begin
                en_out_byte  = 1'b1;
                s_out_byte   = 2'd2;
                en_curr_addr = 1'b1;
                s_curr_addr  = 2'd1;
                if (key_cnt_q != '1) begin
                    key_cnt_d = key_cnt_q + CNT_W'(1);
                end
                state_d = StTxGo;
            end
            StTxGo, StEndGo: begin
                en_uart_tx_go = 1'b1;
                s_uart_tx_go  = 1'b1;
                state_d       = (state_q == StTxGo) ? StTxClr : StEndClr;
            end
            StTxClr, StEndClr: begin
                en_uart_tx_go = 1'b1;
                tmo_d         = '0;
                state_d       = (state_q == StTxClr) ? StTxWait : StEndWait;
            end
            StTxWait, StEndWait: begin
                if (tx_done || tmo_tx_last) begin
                    tmo_d   = '0;
                    state_d = (state_q == StTxWait) ? StRomWait : StDone;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StRomWait: begin
                if (tmo_rom_last) begin
                    tmo_d   = '0;
                    state_d = StKey;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StEndCr: begin
                en_stopwatch_start = 1'b1;
                en_out_byte        = 1'b1;
                state_d            = StEndGo;
            end
            StDone: begin
                if (start_of_game) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign game_active = (state_q != StIdle) && (state_q != StDone);
    assign key_count   = key_cnt_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_typing_test_ctrl.sv
// Bench for typing_test_ctrl: a small behavioural datapath (address reg, ROM, TX byte/go regs,
// stopwatch run reg, UART TX) around the controller, with a scoreboard of echoed bytes.
module tb_typing_test_ctrl;
    localparam int unsigned ROM_LAT    = 2;
    localparam int unsigned TX_TIMEOUT = 20;
    localparam int unsigned CNT_W      = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             uart_pressed_eq_1, start_of_game, rom_eq_uart, end_of_game;
    logic             stopwatch_start_eq_0_and_rom_eq_0, tx_done;
    logic             en_curr_addr, en_stopwatch_rst, s_stopwatch_rst;
    logic             en_stopwatch_start, s_stopwatch_start, en_out_byte;
    logic             en_uart_tx_go, s_uart_tx_go, game_active;
    logic [1:0]       s_curr_addr, s_out_byte;
    logic [CNT_W-1:0] key_count, err_count;

    typing_test_ctrl #(
        .ROM_LAT    (ROM_LAT),
        .TX_TIMEOUT (TX_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk                               (clk),
        .rst                               (rst),
        .uart_pressed_eq_1                 (uart_pressed_eq_1),
        .start_of_game                     (start_of_game),
        .rom_eq_uart                       (rom_eq_uart),
        .end_of_game                       (end_of_game),
        .stopwatch_start_eq_0_and_rom_eq_0 (stopwatch_start_eq_0_and_rom_eq_0),
        .tx_done                           (tx_done),
        .en_curr_addr                      (en_curr_addr),
        .s_curr_addr                       (s_curr_addr),
        .en_stopwatch_rst                  (en_stopwatch_rst),
        .s_stopwatch_rst                   (s_stopwatch_rst),
        .en_stopwatch_start                (en_stopwatch_start),
        .s_stopwatch_start                 (s_stopwatch_start),
        .en_out_byte                       (en_out_byte),
        .s_out_byte                        (s_out_byte),
        .en_uart_tx_go                     (en_uart_tx_go),
        .s_uart_tx_go                      (s_uart_tx_go),
        .game_active                       (game_active),
        .key_count                         (key_count),
        .err_count                         (err_count)
    );

    // Behavioural datapath
    logic [7:0]  rom [0:15];
    logic [10:0] addr_q;
    logic [7:0]  rom_dout_q, out_byte_q, rx_byte;
    logic        rx_valid, sw_at_end, tx_hold;
    logic        tx_go_q, tx_go_d1, sw_start_q;
    int          tx_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            rom_dout_q <= '0;
            out_byte_q <= '0;
            tx_go_q    <= 1'b0;
            tx_go_d1   <= 1'b0;
            sw_start_q <= 1'b0;
            tx_busy    <= 0;
            tx_done    <= 1'b0;
        end else begin
            if (en_curr_addr) begin
                case (s_curr_addr)
                    2'd0:    addr_q <= '0;
                    2'd1:    addr_q <= addr_q + 11'd1;
                    default: addr_q <= addr_q;
                endcase
            end
            rom_dout_q <= rom[addr_q[3:0]];
            if (en_out_byte) begin
                case (s_out_byte)
                    2'd0:    out_byte_q <= 8'h0D;
                    2'd1:    out_byte_q <= rom_dout_q;
                    default: out_byte_q <= rx_byte;
                endcase
            end
            if (en_uart_tx_go) tx_go_q <= s_uart_tx_go;
            if (en_stopwatch_start) sw_start_q <= s_stopwatch_start;
            tx_go_d1 <= tx_go_q;
            tx_done  <= 1'b0;
            if (tx_go_q && !tx_go_d1) begin
                tx_busy <= 3;
            end else if (tx_busy != 0) begin
                tx_busy <= tx_busy - 1;
                if (tx_busy == 1 && !tx_hold) tx_done <= 1'b1;
            end
        end
    end

    assign uart_pressed_eq_1 = rx_valid;
    assign start_of_game     = rx_valid && (rx_byte == 8'h0D);
    assign rom_eq_uart       = (rx_byte == rom_dout_q);
    assign end_of_game       = sw_at_end || (rom_dout_q == 8'h00);
    assign stopwatch_start_eq_0_and_rom_eq_0 = !sw_start_q && (rom_dout_q == 8'h00);

    wire in_key    = en_curr_addr && (s_curr_addr == 2'd2);
    wire in_idle   = en_curr_addr && (s_curr_addr == 2'd0);
    wire in_done   = !game_active && !en_curr_addr;
    wire in_tx_clr = en_uart_tx_go && !s_uart_tx_go && game_active;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    logic sw_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each TX go rising edge must carry the next expected byte.
    always @(negedge clk) begin
        if (sw_start_q) sw_seen = 1'b1;
        if (!rst && tx_go_q && !tx_go_d1) begin
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL tx_extra: observed byte %0h expected none", out_byte_q);
                end
            end else begin
                check("tx_byte", {24'd0, out_byte_q}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic set_rom(input string s);
        for (int i = 0; i < 16; i++) rom[i] = (i < s.len()) ? s[i] : 8'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic enter();
        @(negedge clk);
        rx_byte  = 8'h0D;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_key();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_key && n < 300);
        if (!in_key) check("wait_key", {31'd0, in_key}, 32'd1);
    endtask

    task automatic press(input logic [7:0] b);
        wait_key();
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx_clr();
        int n = 0;
        while (!in_tx_clr && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_tx_clr) check("wait_tx_clr", {31'd0, in_tx_clr}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_done && n < 300);
        check("reach_done", {31'd0, in_done}, 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; sw_at_end = 1'b0; tx_hold = 1'b0;
        sw_seen = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        repeat (3) @(negedge clk);
        // Reset decode
        check("rst_addr", {en_curr_addr, s_curr_addr}, 3'b1_00);
        check("rst_sw", {en_stopwatch_rst, s_stopwatch_rst, en_stopwatch_start,
                         s_stopwatch_start}, 4'b1110);
        check("rst_tx", {en_uart_tx_go, s_uart_tx_go, en_out_byte, game_active}, 4'b1000);
        check("rst_cnt", {key_count, err_count}, 16'h0000);
        rst = 1'b0;

        // 1: "ab" typed correctly
        set_rom("ab");
        enter();
        check("arm_dec", {en_stopwatch_start, s_stopwatch_start, en_stopwatch_rst,
                          s_stopwatch_rst, game_active}, 5'b11101);
        exp_q.push_back("a");
        press("a");
        check("match_dec", {en_out_byte, s_out_byte, en_curr_addr, s_curr_addr}, 6'b1_10_1_01);
        @(negedge clk);
        check("txgo_dec", {en_uart_tx_go, s_uart_tx_go, tx_go_q}, 3'b110);
        @(negedge clk);
        check("tx_latency", {31'd0, tx_go_q}, 32'd1);
        exp_q.push_back("b");
        exp_q.push_back(8'h0D);
        press("b");
        wait_done();
        check("t1_cnt", {key_count, err_count}, {8'd2, 8'd0});
        check("t1_sw", {31'd0, sw_start_q}, 32'd0);
        check("t1_sb", exp_q.size(), 32'd0);
        enter();
        check("t1_idle", {31'd0, in_idle}, 32'd1);

        // 2: wrong keys counted, not echoed
        set_rom("a");
        enter();
        press("x");
        press("x");
        exp_q.push_back("a");
        exp_q.push_back(8'h0D);
        press("a");
        wait_done();
        check("t2_cnt", {key_count, err_count}, {8'd1, 8'd2});
        check("t2_sb", exp_q.size(), 32'd0);
        enter();

        // 3: empty text goes straight to the CR
        set_rom("");
        sw_seen = 1'b0;
        enter();
        check("t3_endcr", {en_out_byte, s_out_byte, en_stopwatch_start, s_stopwatch_start,
                           game_active}, 6'b1_00_1_0_1);
        exp_q.push_back(8'h0D);
        wait_done();
        check("t3_sw_never", {31'd0, sw_seen}, 32'd0);
        check("t3_sb", exp_q.size(), 32'd0);
        enter();

        // 4: tx_done withheld, keys during the wait ignored
        set_rom("abc");
        enter();
        exp_q.push_back("a");
        tx_hold = 1'b1;
        press("a");
        wait_tx_clr();
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (in_key) break;
            n++;
            if (n == 3) begin rx_byte = "b"; rx_valid = 1'b1; end
            if (n == 8) begin rx_byte = "z"; rx_valid = 1'b1; end
            if (n == 4 || n == 9) rx_valid = 1'b0;
        end
        tx_hold = 1'b0;
        check("t4_wait_len", n, TX_TIMEOUT + ROM_LAT);
        check("t4_cnt", {key_count, err_count}, {8'd1, 8'd0});
        wait_key();
        sw_at_end = 1'b1;
        @(negedge clk);
        sw_at_end = 1'b0;
        exp_q.push_back(8'h0D);
        wait_done();
        check("t4_sb", exp_q.size(), 32'd0);
        enter();

        // 5: reset in the middle of TX_WAIT
        set_rom("abcde");
        enter();
        exp_q.push_back("a");
        exp_q.push_back("b");
        exp_q.push_back("c");
        press("a");
        press("b");
        press("z");
        tx_hold = 1'b1;
        press("c");
        wait_tx_clr();
        repeat (2) @(negedge clk);
        check("t5_pre_cnt", {key_count, err_count}, {8'd3, 8'd1});
        rst = 1'b1;
        #1;
        check("t5_rst_cnt", {key_count, err_count}, 16'h0000);
        check("t5_rst_dec", {en_curr_addr, s_curr_addr, en_stopwatch_rst, s_stopwatch_rst},
              5'b1_00_1_1);
        @(negedge clk);
        rst = 1'b0;
        tx_hold = 1'b0;
        check("t5_sb", exp_q.size(), 32'd0);

        // 6: error saturation and end_of_game beating a key
        set_rom("a");
        enter();
        for (int i = 0; i < 256; i++) press("z");
        check("t6_sat", {key_count, err_count}, {8'd0, 8'd255});
        wait_key();
        rx_byte = "a";
        rx_valid = 1'b1;
        sw_at_end = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        sw_at_end = 1'b0;
        check("t6_endcr", {en_out_byte, s_out_byte, en_stopwatch_start, s_stopwatch_start},
              5'b1_00_1_0);
        check("t6_cnt", {key_count, err_count}, {8'd0, 8'd255});
        exp_q.push_back(8'h0D);
        wait_done();
        check("t6_sb", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
